enemy_snapshot_scanner: RTL and testbench
=========================================

// Module: enemy_snapshot_scanner
// PURPOSE
//  Parametrised enemy-state bridge between the fly movement logic and the enemy consumers (renderer, collision).
//  - Captures all N enemy positions and alive flags into a shadow register set once per frame, so consumers see a tear-free view.
//  - Provides a registered alive-enemy count.
//  - Provides a valid/ready scan port that streams the alive enemies one per transfer for the collision unit.
// PARAMETERS
//  N_ENEMY  17   number of enemy channels (1..64)
//  XW       10   x coordinate width
//  YW       10   y coordinate width
//  SCR_W    640  visible width; used only with ENEMY_CLIP_EN
//  SCR_H    480  visible height; used only with ENEMY_CLIP_EN
//  IW       $clog2(N_ENEMY) index width (local); CW = $clog2(N_ENEMY+1) count width (local)
// PORTS
//  clk          in   1          system clock, single domain
//  rst          in   1          asynchronous, active-high reset
//  frame_tick   in   1          1-cycle pulse at start of vblank; requests a snapshot
//  fly_x        in   N*XW       flattened live x, channel i at [i*XW +: XW]
//  fly_y        in   N*YW       flattened live y, channel i at [i*YW +: YW]
//  fly_alive    in   N          live alive flags, bit i = channel i
//  enemy_x      out  N*XW       shadow x (registered)
//  enemy_y      out  N*YW       shadow y (registered)
//  enemy_alive  out  N          shadow alive (registered)
//  alive_count  out  CW         popcount of enemy_alive (registered)
//  snap_done    out  1          1-cycle pulse when shadow + alive_count are updated
//  scan_start   in   1          pulse: begin streaming alive enemies
//  scan_valid   out  1          scan_idx/scan_x/scan_y/scan_last valid
//  scan_ready   in   1          consumer accepts the current entry
//  scan_idx     out  IW         channel index of current entry
//  scan_x       out  XW         shadow x of scan_idx
//  scan_y       out  YW         shadow y of scan_idx
//  scan_last    out  1          current entry is the highest-index alive enemy
//  scan_busy    out  1          FSM not IDLE
//  scan_done    out  1          1-cycle pulse when a scan completes
// BEHAVIOUR
//  Reset
//  - All outputs 0, FSM = IDLE, pointer = 0, pending = 0.
//  Snapshot
//  - In IDLE, at the clk edge sampling frame_tick=1, enemy_x/y/alive load fly_x/y/alive.
//  - Next edge: alive_count updates and snap_done pulses (latency 2 from tick).
//  - frame_tick while scan_busy: sets pending; the shadow stays frozen.
//  - Pending snapshot is taken at the edge leaving DONE (DONE->IDLE).
//  - Multiple ticks while busy merge into a single pending snapshot.
//  FSM: IDLE -> SCAN -> DONE -> IDLE
//  - IDLE: scan_start=1 -> SCAN, pointer = 0.
//      If frame_tick and scan_start coincide, the snapshot is taken first and the scan starts next cycle on the new data.
//  - SCAN, pointer's enemy dead: pointer++ each cycle, scan_valid=0.
//  - SCAN, pointer's enemy alive: scan_valid=1 with outputs from shadow[pointer]; held stable until scan_ready=1.
//  - Accept (valid & ready): pointer++; if scan_last -> DONE.
//  - Pointer reaches N_ENEMY with no alive remaining -> DONE.
//      Zero alive: DONE after N_ENEMY cycles, no valid ever asserted.
//  - DONE: scan_done=1 for one cycle -> IDLE.
//  - scan_last = no alive bit above pointer in enemy_alive (combinational from the shadow mask).
//  - scan_start while busy: ignored.
//  - scan_ready while scan_valid=0: ignored.
//  Boundaries
//  - Pointer never wraps; it uses IW+1 bits internally.
//  - rst mid-scan aborts immediately to the reset state; no scan_done, pending cleared.
//  - Shadow outputs are updated only by a snapshot.
// CONFIGURATION
//  ENEMY_CLIP_EN defined
//  - At snapshot, enemy_alive[i] = fly_alive[i] & (x<SCR_W) & (y<SCR_H).
//  - Off-screen enemies are therefore excluded from alive_count and from the scan.
//  ENEMY_CLIP_EN undefined
//  - Raw copy of fly_alive; SCR_W and SCR_H are unused.
// TESTING
//  1. rst=1 mid-run -> all outputs 0, scan_busy=0; release, no tick -> enemy_alive stays 0.
//  2. fly_alive=17'h1FFFF, x[i]=i*32, tick -> edge+1 enemy_x matches; edge+2 alive_count=17, snap_done=1.
//  3. alive bits {2,5,16}, start, ready=1 -> idx 2,5,16 accepted; last only on 16; scan_done once; busy drops.
//  4. Same as 3 with ready low 3 cycles per entry -> idx/x/y held stable while valid; no entry skipped or repeated.
//  5. Tick during scan after idx 5 accepted -> idx 16 shows old x; snapshot + snap_done after DONE; two ticks -> one snap_done.
//  6. ENEMY_CLIP_EN, alive all, x[3]=700, y[4]=480 -> alive_count=15, scan skips 3 and 4; undefined -> alive_count=17.

Source files
------------

// File: rtl/enemy_snapshot_scanner.sv
// Enemy-state bridge: a tear-free per-frame shadow of all enemy channels, a registered alive count,
// and a valid/ready scan port streaming alive enemies. Optional on-screen clipping: ENEMY_CLIP_EN.
module enemy_snapshot_scanner #(
    parameter int N_ENEMY = 17,
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    localparam int IW     = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1,
    localparam int CW     = $clog2(N_ENEMY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic [N_ENEMY*XW-1:0] fly_x,
    input  logic [N_ENEMY*YW-1:0] fly_y,
    input  logic [N_ENEMY-1:0]    fly_alive,
    output logic [N_ENEMY*XW-1:0] enemy_x,
    output logic [N_ENEMY*YW-1:0] enemy_y,
    output logic [N_ENEMY-1:0]    enemy_alive,
    output logic [CW-1:0]         alive_count,
    output logic                  snap_done,
    input  logic                  scan_start,
    output logic                  scan_valid,
    input  logic                  scan_ready,
    output logic [IW-1:0]         scan_idx,
    output logic [XW-1:0]         scan_x,
    output logic [YW-1:0]         scan_y,
    output logic                  scan_last,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic [1:0]            dbg_state
);
    // Scan handshake: an entry transfers on a clock edge where scan_valid && scan_ready; while
    // scan_valid is high and scan_ready low, scan_idx/x/y/last are held; scan_ready is ignored otherwise.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [IW:0] PTR_LAST = (IW + 1)'(N_ENEMY - 1);

    if (N_ENEMY < 1 || N_ENEMY > 64 || SCR_W < 1 || SCR_H < 1) begin : g_bad_param
        $error("enemy_snapshot_scanner: parameter out of range");
    end

    logic [1:0]            state_q, state_d;
    logic [IW:0]           ptr_q, ptr_d;
    logic                  pending_q, pending_d;
    logic                  defer_q, defer_d;
    logic                  snap_pend_q;
    logic                  snap_done_q;
    logic [N_ENEMY*XW-1:0] enemy_x_q;
    logic [N_ENEMY*YW-1:0] enemy_y_q;
    logic [N_ENEMY-1:0]    enemy_alive_q, alive_d;
    logic [CW-1:0]         alive_count_q, count_d;
    logic                  snap_take;
    logic                  ptr_in, cur_alive, more_above;
    logic [IW-1:0]         ptr_idx;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        defer_d    = 1'b0;
        ptr_in     = (ptr_q <= PTR_LAST);
        ptr_idx    = ptr_q[IW-1:0];
        cur_alive  = ptr_in && enemy_alive_q[ptr_idx];
        more_above = 1'b0;
        for (int i = 0; i < N_ENEMY; i++) begin
            if (i > int'(ptr_q) && enemy_alive_q[i]) more_above = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                // A start coinciding with a tick waits one cycle so it scans the fresh snapshot.
                if (defer_q) begin
                    state_d = S_SCAN;
                    ptr_d   = '0;
                end else if (scan_start && frame_tick) begin
                    defer_d = 1'b1;
                end else if (scan_start) begin
                    state_d = S_SCAN;
                    ptr_d   = '0;
                end
            end
            S_SCAN: begin
                if (!ptr_in) begin
                    state_d = S_DONE;
                end else if (cur_alive) begin
                    if (scan_ready) begin
                        ptr_d = ptr_q + 1'b1;
                        if (!more_above) state_d = S_DONE;
                    end
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        snap_take = ((state_q == S_IDLE) && frame_tick && !defer_q) ||
                    ((state_q == S_DONE) && (pending_q || frame_tick));
        pending_d = pending_q;
        if (snap_take) pending_d = 1'b0;
        else if (frame_tick && ((state_q != S_IDLE) || defer_q)) pending_d = 1'b1;
        alive_d = fly_alive;
`ifdef ENEMY_CLIP_EN
        for (int i = 0; i < N_ENEMY; i++) begin
            alive_d[i] = fly_alive[i] && (int'(fly_x[i*XW +: XW]) < SCR_W) &&
                         (int'(fly_y[i*YW +: YW]) < SCR_H);
        end
`endif
        count_d = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            count_d = count_d + CW'(enemy_alive_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            pending_q     <= 1'b0;
            defer_q       <= 1'b0;
            snap_pend_q   <= 1'b0;
            snap_done_q   <= 1'b0;
            enemy_x_q     <= '0;
            enemy_y_q     <= '0;
            enemy_alive_q <= '0;
            alive_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pending_q   <= pending_d;
            defer_q     <= defer_d;
            snap_pend_q <= snap_take;
            snap_done_q <= snap_pend_q;
            if (snap_take) begin
                enemy_x_q     <= fly_x;
                enemy_y_q     <= fly_y;
                enemy_alive_q <= alive_d;
            end
            if (snap_pend_q) alive_count_q <= count_d;
        end
    end

    always_comb begin
        enemy_x     = enemy_x_q;
        enemy_y     = enemy_y_q;
        enemy_alive = enemy_alive_q;
        alive_count = alive_count_q;
        snap_done   = snap_done_q;
        scan_busy   = (state_q != S_IDLE);
        scan_done   = (state_q == S_DONE);
        dbg_state   = state_q;
        scan_valid  = (state_q == S_SCAN) && cur_alive;
        scan_last   = scan_valid && !more_above;
        scan_idx    = scan_valid ? ptr_idx : '0;
        scan_x      = scan_valid ? enemy_x_q[ptr_idx*XW +: XW] : '0;
        scan_y      = scan_valid ? enemy_y_q[ptr_idx*YW +: YW] : '0;
    end
endmodule

// File: tb/tb_enemy_snapshot_scanner.sv
// Bench for enemy_snapshot_scanner: randomized frames and scans checked against a shadow/scan model.
module tb_enemy_snapshot_scanner;
  localparam int N = 17;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int IW = 5;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  logic frame_tick, scan_start, scan_ready;
  logic [N*XW-1:0] fly_x, enemy_x;
  logic [N*YW-1:0] fly_y, enemy_y;
  logic [N-1:0] fly_alive, enemy_alive;
  logic [CW-1:0] alive_count;
  logic snap_done, scan_valid, scan_last, scan_busy, scan_done;
  logic [IW-1:0] scan_idx;
  logic [XW-1:0] scan_x;
  logic [YW-1:0] scan_y;
  logic [1:0] dbg_state;

  logic [XW-1:0] fx[N];
  logic [YW-1:0] fy[N];

  // reference model: shadow contents after the last snapshot
  int m_x[N];
  int m_y[N];
  bit m_alive[N];

  int got_idx[$];
  int got_x[$];
  int got_y[$];
  bit got_last[$];
  int got_done, got_snap, got_unstable, got_cycles, got_valid_seen;
  bit got_timeout;

  int n_tests = 0;
  int n_fail = 0;

  enemy_snapshot_scanner dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .fly_x(fly_x), .fly_y(fly_y), .fly_alive(fly_alive),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_alive(enemy_alive),
    .alive_count(alive_count), .snap_done(snap_done),
    .scan_start(scan_start), .scan_valid(scan_valid), .scan_ready(scan_ready),
    .scan_idx(scan_idx), .scan_x(scan_x), .scan_y(scan_y), .scan_last(scan_last),
    .scan_busy(scan_busy), .scan_done(scan_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always_comb begin
    fly_x = '0;
    fly_y = '0;
    for (int i = 0; i < N; i++) begin
      fly_x[i*XW +: XW] = fx[i];
      fly_y[i*YW +: YW] = fy[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit on_screen(int x, int y);
`ifdef ENEMY_CLIP_EN
    return (x < 640) && (y < 480);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_snap();
    for (int i = 0; i < N; i++) begin
      m_x[i] = int'(fx[i]);
      m_y[i] = int'(fy[i]);
      m_alive[i] = fly_alive[i] && on_screen(m_x[i], m_y[i]);
    end
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_alive[i]);
    return c;
  endfunction

  function automatic logic [N*XW-1:0] model_x_flat();
    logic [N*XW-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i*XW +: XW] = XW'(m_x[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] model_alive_flat();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_alive[i];
    return v;
  endfunction

  // driver tasks
  task automatic rand_fly(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      fx[i] = XW'($urandom_range(0, 639));
      fy[i] = YW'($urandom_range(0, 479));
    end
    fly_alive = mask;
  endtask

  task automatic do_snapshot();
    frame_tick = 1'b1;
    model_snap();
    step();
    frame_tick = 1'b0;
    step();
    step();
  endtask

  // mode 0: ready always; 1: ready held low 3 cycles per entry; 2: random ready.
  // tick_at >= 0 sends two frame ticks once that many entries have been accepted.
  task automatic run_scan(input int mode, input int tick_at, input bit with_tick);
    int hold = 0;
    int ticks = 0;
    bit r, prev_wait = 1'b0, seen = 1'b0;
    int p_idx = 0, p_x = 0, p_y = 0;
    got_idx.delete(); got_x.delete(); got_y.delete(); got_last.delete();
    got_done = 0; got_snap = 0; got_unstable = 0; got_cycles = -1;
    got_valid_seen = 0; got_timeout = 1'b0;
    scan_start = 1'b1;
    if (with_tick) begin
      frame_tick = 1'b1;
      model_snap();
    end
    step();
    scan_start = 1'b0;
    frame_tick = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (snap_done) got_snap++;
      if (scan_done) begin
        got_done++;
        got_cycles = c;
        seen = 1'b1;
      end else begin
        if (prev_wait && (!scan_valid || int'(scan_idx) != p_idx ||
                          int'(scan_x) != p_x || int'(scan_y) != p_y)) got_unstable++;
        if (scan_valid) begin
          got_valid_seen++;
          case (mode)
            0: r = 1'b1;
            1: r = (hold >= 3);
            default: r = 1'($urandom_range(0, 1));
          endcase
          hold = r ? 0 : hold + 1;
        end else begin
          r = 1'($urandom_range(0, 1));
        end
        scan_ready = r;
        frame_tick = (tick_at >= 0 && got_idx.size() >= tick_at && ticks < 2);
        if (frame_tick) ticks++;
        if (scan_valid && r) begin
          got_idx.push_back(int'(scan_idx));
          got_x.push_back(int'(scan_x));
          got_y.push_back(int'(scan_y));
          got_last.push_back(scan_last);
        end
        prev_wait = scan_valid && !r;
        p_idx = int'(scan_idx);
        p_x = int'(scan_x);
        p_y = int'(scan_y);
        step();
      end
    end
    if (!seen) got_timeout = 1'b1;
    scan_ready = 1'b0;
    frame_tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (scan_done) got_done++;
      if (snap_done) got_snap++;
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (enemy_x !== '0 || enemy_y !== '0 || enemy_alive !== '0) begin
      n_fail++;
      $display("FAIL reset_shadow: x=%h y=%h alive=%h, want 0", enemy_x, enemy_y, enemy_alive);
    end
    n_tests++;
    if ({alive_count, snap_done, scan_valid, scan_idx, scan_x, scan_y, scan_last,
         scan_busy, scan_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: cnt=%0d sd=%b v=%b idx=%0d last=%b busy=%b done=%b, want 0",
               alive_count, snap_done, scan_valid, scan_idx, scan_last, scan_busy, scan_done);
    end
  endtask

  task automatic test_mid_reset();
    rand_fly('1);
    do_snapshot();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    n_tests++;
    if (scan_busy !== 1'b0 || enemy_alive !== '0 || alive_count !== '0 || scan_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b alive=%h cnt=%0d valid=%b, want 0",
               scan_busy, enemy_alive, alive_count, scan_valid);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_alive[i] = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if (enemy_alive !== '0 || scan_done !== 1'b0 || snap_done !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle: alive=%h done=%b snap_done=%b, want 0",
                 enemy_alive, scan_done, snap_done);
      end
    end
  endtask

  task automatic test_snapshot();
    for (int i = 0; i < N; i++) begin
      fx[i] = XW'(i * 32);
      fy[i] = YW'($urandom_range(0, 479));
    end
    fly_alive = '1;
    frame_tick = 1'b1;
    model_snap();
    step();
    frame_tick = 1'b0;
    n_tests++;
    if (enemy_x !== model_x_flat() || snap_done !== 1'b0 || alive_count !== '0) begin
      n_fail++;
      $display("FAIL snap_edge1: x=%h sd=%b cnt=%0d, want x=%h sd=0 cnt=0",
               enemy_x, snap_done, alive_count, model_x_flat());
    end
    step();
    n_tests++;
    if (int'(alive_count) != model_count() || model_count() != 17 || snap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL snap_edge2: cnt=%0d sd=%b, want cnt=17 sd=1", alive_count, snap_done);
    end
    step();
    n_tests++;
    if (snap_done !== 1'b0) begin
      n_fail++;
      $display("FAIL snap_pulse: snap_done=%b, want 0", snap_done);
    end
  endtask

  task automatic test_scan_stream(input int mode, input int reps);
    logic [N-1:0] mask;
    int exp_q[$];
    for (int r = 0; r < reps; r++) begin
      mask = (r == 0) ? N'(17'h10024) : N'($urandom_range(0, (1 << N) - 1));
      rand_fly(mask);
      do_snapshot();
      exp_q.delete();
      for (int i = 0; i < N; i++) if (m_alive[i]) exp_q.push_back(i);
      run_scan(mode, -1, 1'b0);
      n_tests++;
      if (got_idx.size() != exp_q.size() || got_timeout) begin
        n_fail++;
        $display("FAIL scan_count m%0d: got %0d entries (timeout=%b), want %0d",
                 mode, got_idx.size(), got_timeout, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_idx.size(); k++) begin
        n_tests++;
        if (got_idx[k] != exp_q[k] || got_x[k] != m_x[exp_q[k]] || got_y[k] != m_y[exp_q[k]] ||
            got_last[k] != (k == exp_q.size() - 1)) begin
          n_fail++;
          $display("FAIL scan_entry m%0d #%0d: idx=%0d x=%0d y=%0d last=%b, want idx=%0d x=%0d y=%0d last=%b",
                   mode, k, got_idx[k], got_x[k], got_y[k], got_last[k], exp_q[k],
                   m_x[exp_q[k]], m_y[exp_q[k]], k == exp_q.size() - 1);
        end
      end
      n_tests++;
      if (got_done != 1 || got_unstable != 0 || scan_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_end m%0d: dones=%0d unstable=%0d busy=%b, want 1 0 0",
                 mode, got_done, got_unstable, scan_busy);
      end
    end
  endtask

  task automatic test_tick_during_scan();
    rand_fly(N'(17'h10024));
    do_snapshot();
    rand_fly(N'($urandom_range(1, (1 << N) - 1)));
    run_scan(0, 2, 1'b0);
    n_tests++;
    if (got_idx.size() != 3 || got_timeout) begin
      n_fail++;
      $display("FAIL tick_scan_count: got %0d, want 3", got_idx.size());
    end else begin
      n_tests++;
      if (got_idx[2] != 16 || got_x[2] != m_x[16] || got_y[2] != m_y[16]) begin
        n_fail++;
        $display("FAIL tick_scan_frozen: idx=%0d x=%0d y=%0d, want idx=16 x=%0d y=%0d",
                 got_idx[2], got_x[2], got_y[2], m_x[16], m_y[16]);
      end
    end
    n_tests++;
    if (got_snap != 1) begin
      n_fail++;
      $display("FAIL tick_merge: snap_done pulses=%0d, want 1", got_snap);
    end
    model_snap();
    n_tests++;
    if (enemy_x !== model_x_flat() || enemy_alive !== model_alive_flat() ||
        int'(alive_count) != model_count()) begin
      n_fail++;
      $display("FAIL tick_pending_snap: alive=%h cnt=%0d, want alive=%h cnt=%0d",
               enemy_alive, alive_count, model_alive_flat(), model_count());
    end
  endtask

  task automatic test_zero_alive();
    rand_fly('0);
    do_snapshot();
    run_scan(2, -1, 1'b0);
    n_tests++;
    if (got_cycles != N || got_valid_seen != 0 || got_done != 1) begin
      n_fail++;
      $display("FAIL zero_alive: cycles=%0d valids=%0d dones=%0d, want %0d 0 1",
               got_cycles, got_valid_seen, got_done, N);
    end
  endtask

  task automatic test_coincide();
    int exp_q[$];
    rand_fly(N'($urandom_range(1, (1 << N) - 1)));
    run_scan(0, -1, 1'b1);
    for (int i = 0; i < N; i++) if (m_alive[i]) exp_q.push_back(i);
    n_tests++;
    if (got_idx != exp_q || got_done != 1) begin
      n_fail++;
      $display("FAIL coincide: got %0d entries dones=%0d, want %0d entries 1 done",
               got_idx.size(), got_done, exp_q.size());
    end
    for (int k = 0; k < got_idx.size(); k++) begin
      n_tests++;
      if (got_x[k] != m_x[got_idx[k]]) begin
        n_fail++;
        $display("FAIL coincide_x #%0d: x=%0d, want %0d", k, got_x[k], m_x[got_idx[k]]);
      end
    end
  endtask

  task automatic test_clip();
    int exp_q[$];
    rand_fly('1);
    fx[3] = XW'(700);
    fy[4] = YW'(480);
    do_snapshot();
    n_tests++;
`ifdef ENEMY_CLIP_EN
    if (int'(alive_count) != 15) begin
`else
    if (int'(alive_count) != 17) begin
`endif
      n_fail++;
      $display("FAIL clip_count: cnt=%0d, want %0d", alive_count, model_count());
    end
    for (int i = 0; i < N; i++) if (m_alive[i]) exp_q.push_back(i);
    run_scan(0, -1, 1'b0);
    n_tests++;
    if (got_idx != exp_q) begin
      n_fail++;
      $display("FAIL clip_scan: got %0d entries, want %0d", got_idx.size(), exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    scan_start = 1'b0;
    scan_ready = 1'b0;
    rand_fly('0);
    #1;
    test_reset();
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_mid_reset();
    test_snapshot();
    test_scan_stream(0, 4);
    test_scan_stream(1, 3);
    test_scan_stream(2, 6);
    test_tick_during_scan();
    test_zero_alive();
    test_coincide();
    test_clip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
